// File: rtl/timer_irq_pkg.sv
// Shared defaults and helpers for the timer_irq event collector.
// Miss counters exist only when TIMER_IRQ_MISS_EN is defined.
package timer_irq_pkg;

  localparam int N_DEFAULT  = 4;
  localparam int CW_DEFAULT = 4;

  // Smallest id width with 2**w >= n, never below one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Base bit of channel i inside the packed miss vector.
  function automatic int miss_base(input int i, input int cw);
    return i * cw;
  endfunction

endpackage

// File: rtl/timer_irq_chan.sv
// One event channel: edge detector, sticky pending bit and optional
// saturating miss counter (TIMER_IRQ_MISS_EN).
module timer_irq_chan
  import timer_irq_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          event_line,
  input  logic          ack,
  output logic          pending,
  output logic [CW-1:0] miss
);

  logic prev_reg;
  logic pending_reg;
  logic rise;

  assign rise = event_line & ~prev_reg;

  // A rise always wins over a coincident acknowledge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_reg    <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      prev_reg <= event_line;
      if (rise)
        pending_reg <= 1'b1;
      else if (ack)
        pending_reg <= 1'b0;
    end
  end

  assign pending = pending_reg;

`ifdef TIMER_IRQ_MISS_EN
  logic [CW-1:0] miss_reg;

  // Acknowledge clears the count even when a rise coincides.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      miss_reg <= '0;
    else if (ack)
      miss_reg <= '0;
    else if (rise && pending_reg && (miss_reg != {CW{1'b1}}))
      miss_reg <= miss_reg + CW'(1);
  end

  assign miss = miss_reg;
`else
  assign miss = '0;
`endif

endmodule

// File: rtl/timer_irq.sv
// Timer event collector: per-channel sticky pending bits, mask register,
// lowest-index interrupt id. Miss counters enabled by TIMER_IRQ_MISS_EN.
module timer_irq
  import timer_irq_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int CW = CW_DEFAULT,
  parameter int IW = id_width(N)
) (
  input  logic            reset,
  input  logic            clock,
  input  logic [N-1:0]    events,
  input  logic            mask_put,
  input  logic [N-1:0]    mask_value,
  input  logic            ack_put,
  input  logic [N-1:0]    ack_value,
  output logic [N-1:0]    pending,
  output logic            irq,
  output logic [IW-1:0]   id,
  output logic [N*CW-1:0] miss
);

  logic [N-1:0] mask_reg;
  logic [N-1:0] active;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      mask_reg <= '0;
    else if (mask_put)
      mask_reg <= mask_value;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    timer_irq_chan #(
      .CW(CW)
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .event_line(events[gi]),
      .ack       (ack_put & ack_value[gi]),
      .pending   (pending[gi]),
      .miss      (miss[miss_base(gi, CW) +: CW])
    );
  end

  // irq and id depend on registers only.
  assign active = pending & mask_reg;
  assign irq    = |active;

  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (active[i])
        id = IW'(i);
    end
  end

endmodule

// File: tb/tb_timer_irq.sv
// Self-checking bench for timer_irq: directed scenarios plus random traffic
// against a behavioural model of the event collector.
module tb_timer_irq;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int IW = 2;
  localparam int SAT = (1 << CW) - 1;

  logic            reset;
  logic            clock;
  logic [N-1:0]    events;
  logic            mask_put;
  logic [N-1:0]    mask_value;
  logic            ack_put;
  logic [N-1:0]    ack_value;
  logic [N-1:0]    pending;
  logic            irq;
  logic [IW-1:0]   id;
  logic [N*CW-1:0] miss;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural model state
  logic [N-1:0] m_pend;
  logic [N-1:0] m_mask;
  logic [N-1:0] m_last;
  int           m_miss [N];

  timer_irq #(.N(N), .CW(CW), .IW(IW)) dut (
    .reset     (reset),
    .clock     (clock),
    .events    (events),
    .mask_put  (mask_put),
    .mask_value(mask_value),
    .ack_put   (ack_put),
    .ack_value (ack_value),
    .pending   (pending),
    .irq       (irq),
    .id        (id),
    .miss      (miss)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void model_reset();
    m_pend = '0;
    m_mask = '0;
    m_last = '0;
    for (int i = 0; i < N; i++) m_miss[i] = 0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] ev, input logic mp, input logic [N-1:0] mv,
                                     input logic ap, input logic [N-1:0] av);
    for (int i = 0; i < N; i++) begin
      bit rise = ev[i] && !m_last[i];
      bit ackd = ap && av[i];
      if (ackd) m_miss[i] = 0;
      else if (rise && m_pend[i]) m_miss[i] = (m_miss[i] + 1 > SAT) ? SAT : m_miss[i] + 1;
      if (rise) m_pend[i] = 1'b1;
      else if (ackd) m_pend[i] = 1'b0;
    end
    m_last = ev;
    if (mp) m_mask = mv;
  endfunction

  function automatic logic exp_irq();
    return (m_pend & m_mask) != '0;
  endfunction

  function automatic logic [IW-1:0] exp_id();
    for (int i = 0; i < N; i++)
      if (m_pend[i] && m_mask[i]) return IW'(i);
    return '0;
  endfunction

  function automatic logic [N*CW-1:0] exp_miss();
    logic [N*CW-1:0] r;
    r = '0;
`ifdef TIMER_IRQ_MISS_EN
    for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(m_miss[i]);
`endif
    return r;
  endfunction

  // Apply one cycle of stimulus, advance DUT and model, land 1 time unit after the edge.
  task automatic cycle(input logic [N-1:0] ev, input logic mp = 1'b0, input logic [N-1:0] mv = '0,
                       input logic ap = 1'b0, input logic [N-1:0] av = '0);
    events     = ev;
    mask_put   = mp;
    mask_value = mv;
    ack_put    = ap;
    ack_value  = av;
    @(posedge clock);
    model_edge(ev, mp, mv, ap, av);
    #1;
    mask_put = 1'b0;
    ack_put  = 1'b0;
    cyc++;
    $display("cyc %0d ev=%b mput=%0b mval=%b aput=%0b aval=%b -> pending=%b irq=%0b id=%0d miss=%h",
             cyc, ev, mp, mv, ap, av, pending, irq, id, miss);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    events = '0; mask_put = 1'b0; mask_value = '0; ack_put = 1'b0; ack_value = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending got=%b exp=0", pending); end
    checks++; if (irq !== 1'b0 || id !== '0) begin errors++; $display("FAIL reset_irq got irq=%b id=%0d exp 0/0", irq, id); end
    checks++; if (miss !== '0) begin errors++; $display("FAIL reset_miss got=%h exp=0", miss); end
    reset = 1'b0;
  endtask

  task automatic test_mask();
    cycle(4'b0010);
    checks++; if (pending !== 4'b0010 || irq !== 1'b0) begin errors++; $display("FAIL mask_pulse got pending=%b irq=%b exp 0010/0", pending, irq); end
    cycle(4'b0000);
    cycle(4'b0000, 1'b1, 4'b0010);
    checks++; if (irq !== 1'b1 || id !== 2'd1) begin errors++; $display("FAIL mask_unmask got irq=%b id=%0d exp 1/1", irq, id); end
  endtask

  task automatic test_priority_ack();
    cycle(4'b0000, 1'b1, 4'b1111, 1'b1, 4'b0010);
    checks++; if (pending !== 4'b0000 || irq !== 1'b0) begin errors++; $display("FAIL mask_and_ack got pending=%b irq=%b exp 0000/0", pending, irq); end
    cycle(4'b0101);
    checks++; if (pending !== 4'b0101 || id !== 2'd0 || irq !== 1'b1) begin errors++; $display("FAIL prio_tie got pending=%b id=%0d irq=%b exp 0101/0/1", pending, id, irq); end
    cycle(4'b0000, 1'b0, '0, 1'b1, 4'b0001);
    checks++; if (pending !== 4'b0100 || id !== 2'd2) begin errors++; $display("FAIL ack0 got pending=%b id=%0d exp 0100/2", pending, id); end
    cycle(4'b0000, 1'b0, '0, 1'b1, 4'b0100);
    checks++; if (irq !== 1'b0 || id !== 2'd0) begin errors++; $display("FAIL ack2 got irq=%b id=%0d exp 0/0", irq, id); end
  endtask

  task automatic test_held();
    repeat (6) cycle(4'b1000);
    checks++; if (pending[3] !== 1'b1 || miss[3*CW +: CW] !== '0) begin errors++; $display("FAIL held_once got pend3=%b miss3=%0d exp 1/0", pending[3], miss[3*CW +: CW]); end
    cycle(4'b1000, 1'b0, '0, 1'b1, 4'b1000);
    cycle(4'b1000);
    checks++; if (pending[3] !== 1'b0) begin errors++; $display("FAIL held_ack got pend3=%b exp 0", pending[3]); end
    cycle(4'b0000);
  endtask

  task automatic test_saturate();
    logic [CW-1:0] want;
`ifdef TIMER_IRQ_MISS_EN
    want = CW'(SAT);
`else
    want = '0;
`endif
    repeat (20) begin
      cycle(4'b0100);
      cycle(4'b0000);
    end
    checks++; if (pending[2] !== 1'b1 || miss[2*CW +: CW] !== want) begin errors++; $display("FAIL saturate got pend2=%b miss2=%0d exp 1/%0d", pending[2], miss[2*CW +: CW], want); end
    cycle(4'b0000, 1'b0, '0, 1'b1, 4'b0100);
    checks++; if (pending[2] !== 1'b0 || miss[2*CW +: CW] !== '0) begin errors++; $display("FAIL sat_ack got pend2=%b miss2=%0d exp 0/0", pending[2], miss[2*CW +: CW]); end
  endtask

  task automatic test_set_over_ack();
    cycle(4'b0010);
    cycle(4'b0000);
    cycle(4'b0010);
    cycle(4'b0000);
    checks++; if (miss !== exp_miss()) begin errors++; $display("FAIL pre_miss got=%h exp=%h", miss, exp_miss()); end
    cycle(4'b0010, 1'b0, '0, 1'b1, 4'b0010);
    checks++; if (pending[1] !== 1'b1 || miss[1*CW +: CW] !== '0) begin errors++; $display("FAIL set_wins got pend1=%b miss1=%0d exp 1/0", pending[1], miss[1*CW +: CW]); end
    cycle(4'b0000, 1'b0, '0, 1'b1, 4'b0010);
  endtask

  task automatic test_async_reset();
    cycle(4'b1010);
    cycle(4'b0000);
    checks++; if (pending !== 4'b1010 || irq !== 1'b1 || id !== 2'd1) begin errors++; $display("FAIL pre_reset got pending=%b irq=%b id=%0d exp 1010/1/1", pending, irq, id); end
    events = 4'b0001;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (pending !== '0 || irq !== 1'b0 || id !== '0 || miss !== '0) begin errors++; $display("FAIL async_reset got pending=%b irq=%b id=%0d miss=%h exp all 0", pending, irq, id, miss); end
    model_reset();
    @(posedge clock);
    #3;
    reset = 1'b0;
    cycle(4'b0001);
    checks++; if (pending !== 4'b0001 || irq !== 1'b0) begin errors++; $display("FAIL held_release got pending=%b irq=%b exp 0001/0", pending, irq); end
    cycle(4'b0000, 1'b0, '0, 1'b1, 4'b0001);
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      logic [N-1:0] ev, mv, av;
      logic mp, ap;
      ev = N'($urandom);
      mv = N'($urandom);
      av = N'($urandom);
      mp = ($urandom_range(0, 7) == 0);
      ap = ($urandom_range(0, 5) == 0);
      cycle(ev, mp, mv, ap, av);
      checks++;
      if (pending !== m_pend || irq !== exp_irq() || id !== exp_id() || miss !== exp_miss()) begin
        errors++;
        $display("FAIL random got pending=%b irq=%b id=%0d miss=%h exp pending=%b irq=%b id=%0d miss=%h",
                 pending, irq, id, miss, m_pend, exp_irq(), exp_id(), exp_miss());
      end
    end
  endtask

  initial begin
    test_reset();
    test_mask();
    test_priority_ack();
    test_held();
    test_saturate();
    test_set_over_ack();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_irq.md
Name: timer_irq

Overview:
Event collector downstream of the timer blocks (alarm, timeout, pulse, strobe).
- Takes their 1-bit outputs as event lines and detects rising edges.
- Latches each edge into a sticky pending bit, gates pending bits by a mask register and raises a single interrupt.
- Reports the lowest-numbered active channel.
- Counts events lost while a channel is already pending.

Parameters:
N, 4, number of event channels (1..16)
CW, 4, width of per-channel miss counter
IW, 2, id width; must satisfy 2**IW >= N

Ports:
reset  in  1  asynchronous, active-high reset
clock  in  1  single clock, rising edge
event  in  N  timer outputs, level or pulse; bit i = channel i
mask_put  in  1  load strobe for mask register
mask_value  in  N  new mask; 1 = channel enabled
ack_put  in  1  acknowledge strobe
ack_value  in  N  write-1-to-clear pending/miss per channel
pending  out  N  sticky pending bits, unmasked
irq  out  1  any pending & mask
id  out  IW  lowest index i with pending[i] & mask[i]; 0 when irq = 0
miss  out  N*CW  miss counters, channel i at [i*CW +: CW]

Behaviour:
- Reset is asynchronous, active-high. While asserted: prev = 0, pending = 0, mask = 0, miss = 0; hence irq = 0 and id = 0.
- Edge detect:
  - prev[i] <= event[i] every edge.
  - rise[i] = event[i] & ~prev[i], combinational.
  - An event already high at reset release is counted as a rise on the first edge.
  - An event held high for many cycles produces exactly one rise.
- Pending, per channel, evaluated at each edge:
  - rise = 1: pending <= 1. Set wins over a coincident ack.
  - else ack_put & ack_value[i]: pending <= 0.
  - else: hold.
- Latency: pending is visible after the first clock edge at which event is sampled high, i.e. one cycle.
- Miss counter, per channel:
  - rise & pending & ~(ack_put & ack_value[i]): miss <= miss + 1, saturating at 2**CW-1. No wrap.
  - ack_put & ack_value[i]: miss <= 0, including when a rise coincides; that rise lands in pending.
- Mask:
  - mask_put: mask <= mask_value, effective from the next edge.
  - Masking never clears pending; unmasking a pending channel raises irq immediately after the mask edge.
- irq and id are combinational from registers only (pending, mask). There is no combinational path from any input.
- id priority: lowest index wins. Ties at a single edge resolve the same way.
- mask_put and ack_put may be asserted in the same cycle; both take effect.
- Reset mid-operation clears all state immediately, without waiting for clock.

Optional Feature:
TIMER_IRQ_MISS_EN
- Defined: miss counters are implemented as described above.
- Undefined: no counter registers; the miss port is tied to 0. All other behaviour is unchanged.

Decomposition:
- Shared package (timer_irq_pkg):
  - default N, CW
  - the id width rule
  - the miss slice helper: base index i*CW
- Natural sub-module: timer_irq_chan. One instance per channel, generated N times. It holds prev, pending and miss for that channel.
- Top level holds:
  - the mask register
  - the lowest-index priority encoder
  - the irq OR-reduction

Test Plan:
- N=4, CW=4. Reset, then a 1-cycle pulse on event[1] -> pending=4'b0010, irq=0 (mask=0). Then mask_put with 4'b0010 -> next cycle irq=1, id=1.
- mask=4'b1111; event[0] and event[2] rise in the same cycle -> pending=4'b0101, id=0. Then ack 4'b0001 -> pending=4'b0100, id=2. Then ack 4'b0100 -> irq=0, id=0.
- event[3] held high 6 cycles -> single rise: pending[3]=1, miss[3]=0. Ack while still high -> pending[3]=0, no re-set.
- 20 separate pulses on event[2] with no ack (miss enabled) -> pending[2]=1, miss[2]=15, saturated. Then ack 4'b0100 -> miss[2]=0, pending[2]=0.
- Channel 1 pending; new rise on event[1] in the same cycle as ack 4'b0010 -> pending[1] stays 1, miss[1]=0.
- Reset pulsed mid-run with pending=4'b1010 and mask=4'b1111 -> irq, pending, mask, miss drop to 0 asynchronously. event[0] held high across reset release -> pending[0]=1 after the first edge.
